seq_detector: RTL and testbench

//   Serial bit-stream pattern detector. Samples one bit per clock on din and

---
 rtl/seq_detector_if.sv | 12 +
 rtl/seq_detector.sv | 52 +++++
 tb/tb_seq_detector.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_detector_if.sv
// Serial detector bundle: bit stream in, match pulse and running match count out.
// master drives din; slave (the detector) drives flag and match_cnt.
interface seq_detector_if #(
    parameter int CNT_W = 16
);
    logic             din;
    logic             flag;
    logic [CNT_W-1:0] match_cnt;

    modport master (output din, input  flag, input  match_cnt);
    modport slave  (input  din, output flag, output match_cnt);
endinterface

// File: rtl/seq_detector.sv
// Serial pattern finder: matches last PAT_LEN bits of din against PATTERN, saturating match count.
// Latency: flag registered on the edge sampling the final pattern bit, visible the next cycle.
// Backpressure: none; one bit consumed every clock.
module seq_detector #(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    seq_detector_if.slave bus
);

    localparam int             VW   = $clog2(PAT_LEN + 1);
    localparam logic [VW-1:0]  FULL = VW'(PAT_LEN);

    logic [PAT_LEN-2:0] hist;
    logic [PAT_LEN-1:0] hist_nxt;
    logic [VW-1:0]      vcnt;
    logic [VW-1:0]      vcnt_nxt;
    logic               hit;
    logic               flag_q;
    logic [CNT_W-1:0]   cnt_q;

    // vcnt tracks how many post-reset bits are in the window, so stale or
    // reset-straddling history can never produce a match.
    always_comb begin
        hist_nxt = {hist, bus.din};
        vcnt_nxt = (vcnt == FULL) ? vcnt : vcnt + VW'(1);
        hit      = (hist_nxt == PATTERN) && (vcnt_nxt == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist   <= '0;
            vcnt   <= '0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist   <= hist_nxt[PAT_LEN-2:0];
            vcnt   <= (hit && !OVERLAP) ? '0 : vcnt_nxt;
            flag_q <= hit;
            if (hit && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.flag      = flag_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: four instances (default, no-overlap, 2-bit pattern, 2-bit counter)
// share one stimulus bit and are checked phase by phase against hand-computed vectors.
module tb_seq_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_if #(.CNT_W(16)) ifa ();
    seq_detector_if #(.CNT_W(16)) ifb ();
    seq_detector_if #(.CNT_W(16)) ifc ();
    seq_detector_if #(.CNT_W(2))  ifd ();

    assign ifa.din = din;
    assign ifb.din = din;
    assign ifc.din = din;
    assign ifd.din = din;

    seq_detector #(.PAT_LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b1), .CNT_W(16))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_detector #(.PAT_LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b0), .CNT_W(16))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    seq_detector #(.PAT_LEN(2), .PATTERN(2'b11),    .OVERLAP(1'b1), .CNT_W(16))
        u_c (.clk(clk), .rst(rst), .bus(ifc));
    seq_detector #(.PAT_LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b1), .CNT_W(2))
        u_d (.clk(clk), .rst(rst), .bus(ifd));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one bit, let the edge sample it, then settle before sampling outputs.
    task automatic step(input logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step(1'b1);
        rst = 1'b0;
    endtask

    logic [29:0] stream_v = 30'b000110010001101010010010100010;
    logic [29:0] exp_a    = 30'b000000001000000000001001000000;
    logic [29:0] exp_b    = 30'b000000001000000000001000000000;
    logic [6:0]  t4_in    = 7'b0111110;
    logic [6:0]  t4_exp   = 7'b0011110;
    logic [4:0]  pat5     = 5'b10010;

    initial begin
        // Reset: the two leading word bits (1,1) are sampled under reset and dropped.
        do_reset(2);
        chk("rst_flag_a", {31'b0, ifa.flag}, 32'd0);
        chk("rst_cnt_a",  {16'b0, ifa.match_cnt}, 32'd0);
        chk("rst_cnt_d",  {30'b0, ifd.match_cnt}, 32'd0);

        // Tests 1 and 2: overlap vs. no-overlap on the same stream.
        for (int i = 0; i < 30; i++) begin
            step(stream_v[29-i]);
            chk("t1_flag", {31'b0, ifa.flag}, {31'b0, exp_a[29-i]});
            chk("t2_flag", {31'b0, ifb.flag}, {31'b0, exp_b[29-i]});
        end
        chk("t1_cnt", {16'b0, ifa.match_cnt}, 32'd3);
        chk("t2_cnt", {16'b0, ifb.match_cnt}, 32'd2);

        // Test 3: partial 1001, reset coincident with the would-be final 0, then 0.
        do_reset(2);
        step(1'b1); step(1'b0); step(1'b0); step(1'b1);
        chk("t3_pre_flag", {31'b0, ifa.flag}, 32'd0);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        chk("t3_rst_flag", {31'b0, ifa.flag}, 32'd0);
        chk("t3_rst_cnt",  {16'b0, ifa.match_cnt}, 32'd0);
        step(1'b0);
        chk("t3_flag", {31'b0, ifa.flag}, 32'd0);
        chk("t3_cnt",  {16'b0, ifa.match_cnt}, 32'd0);

        // Test 4: 2-bit pattern 11, back-to-back matches.
        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            step(t4_in[6-i]);
            chk("t4_flag", {31'b0, ifc.flag}, {31'b0, t4_exp[6-i]});
        end
        chk("t4_cnt", {16'b0, ifc.match_cnt}, 32'd4);

        // Test 5: five back-to-back 10010 words; 2-bit counter saturates at 3.
        do_reset(2);
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 5; i++) begin
                step(pat5[4-i]);
                chk("t5_flag", {31'b0, ifd.flag}, (i == 4) ? 32'd1 : 32'd0);
            end
            chk("t5_cnt_d", {30'b0, ifd.match_cnt}, (r >= 2) ? 32'd3 : 32'(r + 1));
        end
        chk("t5_cnt_a", {16'b0, ifa.match_cnt}, 32'd5);

        // Test 6: 64 zeros then 64 ones never match 10010.
        do_reset(2);
        for (int i = 0; i < 128; i++) begin
            step((i < 64) ? 1'b0 : 1'b1);
            chk("t6_flag", {31'b0, ifa.flag}, 32'd0);
        end
        chk("t6_cnt_a", {16'b0, ifa.match_cnt}, 32'd0);
        chk("t6_cnt_b", {16'b0, ifb.match_cnt}, 32'd0);
        chk("t6_cnt_d", {30'b0, ifd.match_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
